// File: rtl/aes_key_expand_seq.sv
// Iterative AES key schedule: produces one 32-bit schedule word per clock and
// presents the complete flat round-key bus (round key 0 in the MSBs) once finished.
module aes_key_expand_seq #(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = NK + 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [32*NK-1:0]        key_in,
  output logic                    busy,
  output logic                    done,
  output logic                    keys_vld,
  output logic [128*(NR+1)-1:0]   keys_out
);

  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned KW = 32 * NW;
  localparam int unsigned IW = $clog2(NW + 1);
  localparam int unsigned MW = $clog2(NK);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [MW-1:0]   mod_q, mod_d;
  logic [7:0]      rcon_q, rcon_d;
  logic [KW-1:0]   keys_q, keys_d;
  logic            done_q, done_d;
  logic            vld_q, vld_d;

  logic [31:0]     w_prev, w_back, sub_in, sub_out, temp, new_w;
  logic            last;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Built as a shift register: the newest word enters at the LSBs, so once all
  // NW words are in, w[0] has arrived at the MSBs.
  assign w_prev = keys_q[31:0];
  assign w_back = keys_q[32*NK-1 -: 32];
  assign last   = (idx_q == IW'(NW - 1));

  always_comb begin
    sub_in  = (mod_q == '0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (mod_q == '0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (NK == 8 && mod_q == MW'(4)) begin
      temp = sub_out;
    end else begin
      temp = w_prev;
    end
    new_w = w_back ^ temp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q == StRun);
    done     = done_q;
    keys_vld = vld_q;
    keys_out = keys_q;
  end

  always_comb begin
    idx_d  = idx_q;
    mod_d  = mod_q;
    rcon_d = rcon_q;
    keys_d = keys_q;
    done_d = 1'b0;
    vld_d  = vld_q;
    if (state_q == StIdle && start) begin
      keys_d              = '0;
      keys_d[32*NK-1:0]   = key_in;
      idx_d               = IW'(NK);
      mod_d               = '0;
      rcon_d              = 8'h01;
      vld_d               = 1'b0;
    end else if (state_q == StRun) begin
      keys_d = {keys_q[KW-33:0], new_w};
      idx_d  = idx_q + 1'b1;
      mod_d  = (mod_q == MW'(NK - 1)) ? '0 : mod_q + 1'b1;
      if (mod_q == '0) rcon_d = xtime(rcon_q);
      if (last) begin
        done_d = 1'b1;
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      mod_q  <= '0;
      rcon_q <= 8'h01;
      keys_q <= '0;
      done_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      mod_q  <= mod_d;
      rcon_q <= rcon_d;
      keys_q <= keys_d;
      done_q <= done_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq: FIPS-197 vectors for AES-128/192/256,
// ignored restart, async reset mid-run, back-to-back start, and a decrypt check.
module tb_aes_key_expand_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start4, start6, start8;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic busy4, done4, vld4, busy6, done6, vld6, busy8, done8, vld8;
  logic [1407:0] keys4;
  logic [1663:0] keys6;
  logic [1919:0] keys8;

  aes_key_expand_seq #(.NK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .key_in(key4),
    .busy(busy4), .done(done4), .keys_vld(vld4), .keys_out(keys4)
  );
  aes_key_expand_seq #(.NK(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .key_in(key6),
    .busy(busy6), .done(done6), .keys_vld(vld6), .keys_out(keys6)
  );
  aes_key_expand_seq #(.NK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .key_in(key8),
    .busy(busy8), .done(done8), .keys_vld(vld8), .keys_out(keys8)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] isb [256];

  localparam logic [127:0] Key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KeyAlt = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if ((d == 4 && done4) || (d == 6 && done6) || (d == 8 && done8)) begin
        lat = n;
        break;
      end
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] fsb(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gm(a, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = isb[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];    a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];    a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm(a0, 8'd14) ^ gm(a1, 8'd11) ^ gm(a2, 8'd13) ^ gm(a3, 8'd9);
      o[119-32*c -: 8] = gm(a0, 8'd9)  ^ gm(a1, 8'd14) ^ gm(a2, 8'd11) ^ gm(a3, 8'd13);
      o[111-32*c -: 8] = gm(a0, 8'd13) ^ gm(a1, 8'd9)  ^ gm(a2, 8'd14) ^ gm(a3, 8'd11);
      o[103-32*c -: 8] = gm(a0, 8'd11) ^ gm(a1, 8'd13) ^ gm(a2, 8'd9)  ^ gm(a3, 8'd14);
    end
    return o;
  endfunction

  function automatic logic [127:0] decrypt(input logic [1407:0] k, input logic [127:0] ct);
    logic [127:0] st;
    st = ct ^ k[127:0];
    for (int r = 9; r >= 1; r--) begin
      st = inv_shift_sub(st) ^ k[1407-128*r -: 128];
      st = inv_mix(st);
    end
    return inv_shift_sub(st) ^ k[1407 -: 128];
  endfunction

  initial begin
    int lat;
    for (int x = 0; x < 256; x++) isb[fsb(8'(x))] = 8'(x);

    rst_n = 1'b0;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    #12;
    check("rst_busy", {127'b0, busy4}, 128'd0);
    check("rst_done", {127'b0, done4}, 128'd0);
    check("rst_vld", {127'b0, vld4}, 128'd0);
    check("rst_keys_zero", {127'b0, (keys4 == '0)}, 128'd1);
    @(negedge clk) rst_n = 1'b1;

    // AES-128
    @(negedge clk); key4 = Key128; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    check("t1_busy", {127'b0, busy4}, 128'd1);
    wait_done(4, lat);
    check("t1_latency", 128'(lat), 128'd40);
    check("t1_vld", {127'b0, vld4}, 128'd1);
    check("t1_busy_low", {127'b0, busy4}, 128'd0);
    check("t1_w4", {96'b0, keys4[1279 -: 32]}, 128'ha0fafe17);
    check("t1_w43", {96'b0, keys4[31:0]}, 128'hb6630ca6);
    check("t1_rk10", keys4[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("t1_rk0", keys4[1407 -: 128], Key128);
    @(posedge clk); #1;
    check("t1_done_pulse", {127'b0, done4}, 128'd0);
    check("t1_vld_hold", {127'b0, vld4}, 128'd1);
    check("t6_decrypt", decrypt(keys4, 128'h3925841d02dc09fbdc118597196a0b32),
          128'h3243f6a8885a308d313198a2e0370734);

    // AES-192
    @(negedge clk); key6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b; start6 = 1'b1;
    @(posedge clk); #1 start6 = 1'b0;
    wait_done(6, lat);
    check("t2_latency", 128'(lat), 128'd46);
    check("t2_w6", {96'b0, keys6[1471 -: 32]}, 128'hfe0c91f7);
    check("t2_w51", {96'b0, keys6[31:0]}, 128'h01002202);

    // AES-256
    @(negedge clk);
    key8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    wait_done(8, lat);
    check("t3_latency", 128'(lat), 128'd52);
    check("t3_w8", {96'b0, keys8[1663 -: 32]}, 128'h9ba35411);
    check("t3_w12", {96'b0, keys8[1535 -: 32]}, 128'ha8b09c1a);
    check("t3_w59", {96'b0, keys8[31:0]}, 128'h706c631e);

    // Restart attempt mid-run with a different key must be ignored
    @(negedge clk); key4 = Key128; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      if (n == 10) begin start4 = 1'b1; key4 = KeyAlt; end
      else start4 = 1'b0;
      @(posedge clk); #1;
      if (done4) begin lat = n; break; end
    end
    start4 = 1'b0;
    check("t4_latency", 128'(lat), 128'd40);
    check("t4_rk10", keys4[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("t4_rk0", keys4[1407 -: 128], Key128);

    // Asynchronous reset mid-run
    @(negedge clk); key4 = Key128; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", {127'b0, busy4}, 128'd0);
    check("t5_done", {127'b0, done4}, 128'd0);
    check("t5_vld", {127'b0, vld4}, 128'd0);
    check("t5_keys_zero", {127'b0, (keys4 == '0)}, 128'd1);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk); start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    wait_done(4, lat);
    check("t5_latency", 128'(lat), 128'd40);
    check("t5_w43", {96'b0, keys4[31:0]}, 128'hb6630ca6);

    // Start in the done cycle is accepted
    start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    check("b2b_vld_drop", {127'b0, vld4}, 128'd0);
    check("b2b_busy", {127'b0, busy4}, 128'd1);
    wait_done(4, lat);
    check("b2b_latency", 128'(lat), 128'd40);
    check("b2b_rk10", keys4[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
